// File: rtl/trap_irq_sequencer.sv
// trap_irq_sequencer: machine-mode trap CSRs, UART interrupt latching and trap/mret redirect sequencing
module trap_irq_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [XLEN-1:0] pc,
    input  logic            csr_wre,
    input  logic            csr_rde,
    input  logic            is_mret,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic            uart_rx_irq,
    input  logic            uart_tx_irq,
    output logic [XLEN-1:0] csr_rdata,
    output logic            kill,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
);
    typedef enum logic {RUN, REDIRECT} state_t;

    state_t          state, state_n;
    logic            mie_b, mpie, rxie, txie, rxp, txp, rx_prev, tx_prev;
    logic [XLEN-1:0] mtvec, mepc, mcause;
    logic            run, take, ret, en_rx, en_tx, wr;
    logic            unused_rde;

    assign unused_rde = csr_rde;
    assign en_rx      = rxp & rxie;
    assign en_tx      = txp & txie;
    assign wr         = csr_wre & instr_valid & ~kill;
    assign redirect   = state == REDIRECT;

    // state register
    always_ff @(posedge clk) begin
        if (!rst) state <= RUN;
        else      state <= state_n;
    end

    // trap/mret decisions; REDIRECT kills the wrong-path instruction and always returns to RUN
    always_comb begin
        run     = state == RUN;
        take    = run & instr_valid & mie_b & ~csr_wre & ~is_mret & (en_rx | en_tx);
        ret     = run & instr_valid & is_mret;
        kill    = take | ~run;
        state_n = (take | ret) ? REDIRECT : RUN;
    end

    // CSR file, pending latches and redirect target; trap/mret updates override a same-cycle write
    always_ff @(posedge clk) begin
        if (!rst) begin
            {mie_b, mpie, rxie, txie, rxp, txp, rx_prev, tx_prev} <= '0;
            mtvec       <= '0;
            mepc        <= '0;
            mcause      <= '0;
            redirect_pc <= '0;
        end else begin
            rx_prev <= uart_rx_irq;
            tx_prev <= uart_tx_irq;
            rxp     <= (uart_rx_irq & ~rx_prev) | (rxp & ~(take & en_rx));
            txp     <= (uart_tx_irq & ~tx_prev) | (txp & ~(take & ~en_rx));
            if (wr) begin
                case (csr_addr)
                    12'h300: {mpie, mie_b} <= {csr_wdata[7], csr_wdata[3]};
                    12'h304: {txie, rxie}  <= csr_wdata[17:16];
                    12'h305: mtvec         <= {csr_wdata[XLEN-1:2], 2'b00};
                    12'h341: mepc          <= {csr_wdata[XLEN-1:2], 2'b00};
                    12'h342: mcause        <= csr_wdata;
                    default: ;
                endcase
            end
            if (take) begin
                mepc        <= {pc[XLEN-1:2], 2'b00};
                mcause      <= en_rx ? 32'h8000_0010 : 32'h8000_0011;
                mpie        <= mie_b;
                mie_b       <= 1'b0;
                redirect_pc <= mtvec;
            end
            if (ret) begin
                mie_b       <= mpie;
                mpie        <= 1'b1;
                redirect_pc <= mepc;
            end
        end
    end

    // combinational CSR read mux
    always_comb begin
        case (csr_addr)
            12'h300: csr_rdata = {24'b0, mpie, 3'b0, mie_b, 3'b0};
            12'h304: csr_rdata = {14'b0, txie, rxie, 16'b0};
            12'h344: csr_rdata = {14'b0, txp, rxp, 16'b0};
            12'h305: csr_rdata = mtvec;
            12'h341: csr_rdata = mepc;
            12'h342: csr_rdata = mcause;
            default: csr_rdata = '0;
        endcase
    end
endmodule

// File: tb/tb_trap_irq_sequencer.sv
// tb_trap_irq_sequencer: vector table plus scoreboard check of trap entry, mret, priority, masking, collision and reset
module tb_trap_irq_sequencer;
    localparam logic [11:0] MST = 12'h300, MIEA = 12'h304, MTV = 12'h305;
    localparam logic [11:0] MEPC = 12'h341, MCA = 12'h342, MIP = 12'h344;

    typedef struct {
        logic        ck, r, iv;
        logic [31:0] pc;
        logic        w, m;
        logic [11:0] a;
        logic [31:0] d;
        logic        rx, tx, k, rr;
        logic [31:0] rpc, rd;
    } vec_t;

    logic        clk = 0, rst, instr_valid, csr_wre, csr_rde, is_mret, uart_rx_irq, uart_tx_irq;
    logic [31:0] pc, csr_wdata, csr_rdata, redirect_pc;
    logic [11:0] csr_addr;
    logic        kill, redirect;
    vec_t        tbl[$];
    vec_t        sb[$];
    int          n_vec = 0, n_err = 0;

    trap_irq_sequencer #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .pc(pc),
        .csr_wre(csr_wre), .csr_rde(csr_rde), .is_mret(is_mret),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .uart_rx_irq(uart_rx_irq), .uart_tx_irq(uart_tx_irq),
        .csr_rdata(csr_rdata), .kill(kill), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic vec_t V(logic ck, logic r, logic iv, logic [31:0] p, logic w, logic m,
                               logic [11:0] a, logic [31:0] d, logic rx, logic tx,
                               logic k, logic rr, logic [31:0] rpc, logic [31:0] rd);
        vec_t v;
        v.ck = ck; v.r = r; v.iv = iv; v.pc = p; v.w = w; v.m = m; v.a = a; v.d = d;
        v.rx = rx; v.tx = tx; v.k = k; v.rr = rr; v.rpc = rpc; v.rd = rd;
        return v;
    endfunction

    task automatic cyc(input vec_t v);
        rst = v.r; instr_valid = v.iv; pc = v.pc; csr_wre = v.w; csr_rde = ~v.w;
        is_mret = v.m; csr_addr = v.a; csr_wdata = v.d; uart_rx_irq = v.rx; uart_tx_irq = v.tx;
        sb.push_back(v);
        @(posedge clk) #1;
    endtask

    // compare outputs mid-cycle against the expectation pushed when the inputs were driven
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            vec_t e;
            e = sb.pop_front();
            if (e.ck) begin
                n_vec += 4;
                if (kill !== e.k) begin n_err++; $display("FAIL kill pc=%h: got %b want %b", e.pc, kill, e.k); end
                if (redirect !== e.rr) begin n_err++; $display("FAIL redirect pc=%h: got %b want %b", e.pc, redirect, e.rr); end
                if (redirect_pc !== e.rpc) begin n_err++; $display("FAIL redirect_pc pc=%h: got %h want %h", e.pc, redirect_pc, e.rpc); end
                if (csr_rdata !== e.rd) begin n_err++; $display("FAIL csr_rdata addr=%h pc=%h: got %h want %h", e.a, e.pc, csr_rdata, e.rd); end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 0; instr_valid = 0; pc = 0; csr_wre = 0; csr_rde = 0; is_mret = 0;
        csr_addr = 0; csr_wdata = 0; uart_rx_irq = 0; uart_tx_irq = 0;
        // reset, CSR setup
        tbl.push_back(V(0,0,0,0,0,0,MST,0,0,0, 0,0,0,0));
        tbl.push_back(V(1,0,0,0,0,0,MST,0,0,0, 0,0,0,0));
        tbl.push_back(V(1,1,1,0,1,0,MTV,32'h103,0,0, 0,0,0,0));
        tbl.push_back(V(1,1,0,0,0,0,MTV,0,0,0, 0,0,0,32'h100));
        tbl.push_back(V(1,1,1,4,1,0,MIEA,32'hFFFF_FFFF,0,0, 0,0,0,0));
        tbl.push_back(V(1,1,0,0,0,0,MIEA,0,0,0, 0,0,0,32'h3_0000));
        tbl.push_back(V(1,1,1,8,1,0,MST,32'h8,0,0, 0,0,0,0));
        tbl.push_back(V(1,1,0,0,0,0,MST,0,0,0, 0,0,0,32'h8));
        // RX trap at pc 0x40, redirect blocks a wrong-path CSR write
        tbl.push_back(V(1,1,0,32'h3c,0,0,MIP,0,1,0, 0,0,0,0));
        tbl.push_back(V(1,1,1,32'h40,0,0,MIP,0,0,0, 1,0,0,32'h1_0000));
        tbl.push_back(V(1,1,1,32'h44,1,0,MCA,32'hDEAD,0,0, 1,1,32'h100,32'h8000_0010));
        tbl.push_back(V(1,1,0,0,0,0,MCA,0,0,0, 0,0,32'h100,32'h8000_0010));
        tbl.push_back(V(1,1,0,0,0,0,MEPC,0,0,0, 0,0,32'h100,32'h40));
        tbl.push_back(V(1,1,0,0,0,0,MST,0,0,0, 0,0,32'h100,32'h80));
        tbl.push_back(V(1,1,0,0,0,0,MIP,0,0,0, 0,0,32'h100,0));
        // mret back to 0x40
        tbl.push_back(V(1,1,1,32'h100,0,1,MST,0,0,0, 0,0,32'h100,32'h80));
        tbl.push_back(V(1,1,1,32'h104,0,0,MST,0,0,0, 1,1,32'h40,32'h88));
        // RX and TX together: RX first, TX after mret
        tbl.push_back(V(1,1,0,0,0,0,MIP,0,1,1, 0,0,32'h40,0));
        tbl.push_back(V(1,1,1,32'h80,0,0,MIP,0,0,0, 1,0,32'h40,32'h3_0000));
        tbl.push_back(V(1,1,0,0,0,0,MCA,0,0,0, 1,1,32'h100,32'h8000_0010));
        tbl.push_back(V(1,1,0,0,0,0,MIP,0,0,0, 0,0,32'h100,32'h2_0000));
        tbl.push_back(V(1,1,1,32'h100,0,1,MEPC,0,0,0, 0,0,32'h100,32'h80));
        tbl.push_back(V(1,1,1,32'h104,0,0,MST,0,0,0, 1,1,32'h80,32'h88));
        tbl.push_back(V(1,1,1,32'h80,0,0,MCA,0,0,0, 1,0,32'h80,32'h8000_0010));
        tbl.push_back(V(1,1,0,0,0,0,MCA,0,0,0, 1,1,32'h100,32'h8000_0011));
        tbl.push_back(V(1,1,0,0,0,0,MIP,0,0,0, 0,0,32'h100,0));
        tbl.push_back(V(1,1,0,0,0,0,MST,0,0,0, 0,0,32'h100,32'h80));
        // masking: pending RX held while MIE=0, taken on first boundary without csr_wre
        tbl.push_back(V(1,1,0,0,0,0,MIP,0,1,0, 0,0,32'h100,0));
        tbl.push_back(V(1,1,1,32'h200,0,0,MIP,0,0,0, 0,0,32'h100,32'h1_0000));
        tbl.push_back(V(1,1,1,32'h204,0,0,MIP,0,0,0, 0,0,32'h100,32'h1_0000));
        tbl.push_back(V(1,1,1,32'h208,1,0,MST,32'h8,0,0, 0,0,32'h100,32'h80));
        tbl.push_back(V(1,1,1,32'h20c,1,0,12'h340,5,0,0, 0,0,32'h100,0));
        tbl.push_back(V(1,1,1,32'h210,0,0,MIP,0,0,0, 1,0,32'h100,32'h1_0000));
        tbl.push_back(V(1,1,1,32'h214,0,0,MEPC,0,0,0, 1,1,32'h100,32'h210));
        tbl.push_back(V(1,1,0,0,0,0,MST,0,0,0, 0,0,32'h100,32'h80));
        tbl.push_back(V(1,1,0,0,0,0,MCA,0,0,0, 0,0,32'h100,32'h8000_0010));
        @(posedge clk) #1;
        foreach (tbl[i]) cyc(tbl[i]);
        // collision: mret with a pending enabled TX; mret redirects first, TX taken after
        cyc(V(1,1,0,0,0,0,MIP,0,0,1, 0,0,32'h100,0));
        cyc(V(1,1,1,32'h100,1,0,MST,32'h88,0,0, 0,0,32'h100,32'h80));
        cyc(V(1,1,1,32'h104,0,1,MIP,0,0,0, 0,0,32'h100,32'h2_0000));
        cyc(V(1,1,1,32'h108,0,0,MST,0,0,0, 1,1,32'h210,32'h88));
        cyc(V(1,1,1,32'h210,0,0,MCA,0,0,0, 1,0,32'h210,32'h8000_0010));
        // reset held two cycles starting mid-REDIRECT, with RX high through release
        cyc(V(1,0,1,32'h214,0,0,MCA,0,1,0, 1,1,32'h100,32'h8000_0011));
        cyc(V(1,0,0,0,0,0,MEPC,0,1,0, 0,0,0,0));
        cyc(V(1,1,0,0,0,0,MIP,0,1,0, 0,0,0,0));
        cyc(V(1,1,0,0,0,0,MIP,0,1,0, 0,0,0,32'h1_0000));
        cyc(V(1,1,0,0,0,0,MST,0,1,0, 0,0,0,0));
        cyc(V(1,1,0,0,0,0,MIEA,0,1,0, 0,0,0,0));
        cyc(V(1,1,0,0,0,0,MTV,0,1,0, 0,0,0,0));
        cyc(V(1,1,0,0,0,0,MEPC,0,1,0, 0,0,0,0));
        cyc(V(1,1,0,0,0,0,MCA,0,1,0, 0,0,0,0));
        @(negedge clk) #1;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard drain: %0d left want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/trap_irq_sequencer.md
# trap_irq_sequencer

Machine-mode trap and interrupt sequencer for the single-cycle RV32 core. It owns the trap CSRs (mstatus, mie, mip, mtvec, mepc, mcause) and latches UART RX/TX interrupt requests. It takes interrupts at instruction boundaries, kills and holds the interrupted instruction, and redirects the PC. It consumes the control unit's `csr_wre`/`csr_rde`/`is_mret` decode and sequences the two-phase trap-entry and mret-return redirect.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-low reset.
- `instr_valid`  in  1  the current-cycle instruction at `pc` is a real instruction.
- `pc`  in  XLEN  PC of the current instruction.
- `csr_wre`, `csr_rde`, `is_mret`  in  1 each  decode strobes from the control unit.
- `csr_addr`  in  12  CSR address (instr[31:20]).
- `csr_wdata`  in  XLEN  final CSR write value; the datapath has already applied set/clear semantics.
- `uart_rx_irq`, `uart_tx_irq`  in  1 each  level requests from the UART.
- `csr_rdata`  out  XLEN  combinational CSR read data.
- `kill`  out  1  combinational; suppresses RegWrite/MemWrite and holds the PC this cycle.
- `redirect`  out  1  registered; load `redirect_pc` into the PC this cycle.
- `redirect_pc`  out  XLEN  registered target.

## Operation
- **CSRs**
  - mstatus 0x300: only bit3 MIE and bit7 MPIE are implemented; all other bits read 0.
  - mie 0x304: bit16 RXIE, bit17 TXIE; all other bits read 0.
  - mip 0x344: read-only; bit16 RXP, bit17 TXP; writes are ignored.
  - mtvec 0x305: direct mode; bits[1:0] are forced to 0 on write.
  - mepc 0x341: bits[1:0] are forced to 0.
  - mcause 0x342: full 32 bits.
  - Unimplemented addresses read 0 and ignore writes.
- **CSR write**: occurs at the clock edge when `csr_wre & instr_valid & ~kill`. `csr_rdata` is valid whenever the address is applied; `csr_rde` is informational only.
- **Pending latches**
  - `irq_prev` registers sample each input every cycle.
  - A rising edge (`irq & ~irq_prev`) sets the matching pending bit.
  - Taking that source's trap clears its bit.
  - If an edge and a clear happen on the same cycle, set wins.
- **Take condition (`take`)**, evaluated in RUN: `instr_valid & MIE & ~csr_wre & ~is_mret & |(mip & mie)`.
  - RX has priority over TX.
- **FSM states**: RUN, REDIRECT.
  - **RUN, on `take`**:
    - `kill`=1 this cycle.
    - At the edge: mepc<=pc; mcause<=0x8000_0010 (RX) or 0x8000_0011 (TX).
    - At the edge: MPIE<=MIE; MIE<=0; the chosen pending bit is cleared.
    - At the edge: redirect_pc<=mtvec; go to REDIRECT.
  - **RUN, on `is_mret & instr_valid`**:
    - The mret instruction is not killed.
    - At the edge: MIE<=MPIE; MPIE<=1; redirect_pc<=mepc; go to REDIRECT.
  - **REDIRECT**: `redirect`=1 and `kill`=1 for the wrong-path instruction, which also blocks any CSR write. Next state is RUN unconditionally. No take or mret is evaluated in this state.
- **Simultaneous events**
  - mret and pending interrupt in the same cycle: mret wins. The interrupt is re-evaluated in RUN after the redirect, with the restored MIE.
  - CSR write and pending interrupt in the same cycle: the write retires; the interrupt waits for the next boundary.
- **Reset** (any cycle, including mid-REDIRECT):
  - All CSRs, pending bits and irq_prev are 0; state is RUN.
  - `redirect`=0, `redirect_pc`=0, `kill`=0, `csr_rdata` reads 0 for all implemented CSRs.
  - An irq input that is high at reset release registers as an edge in the first cycle out of reset.

## Timing
- **Trap entry**:
  - Edge at cycle N: pending is visible in mip at N+1.
  - `take`/`kill` occur in the first eligible cycle T ≥ N+1.
  - `redirect` follows at T+1; the first handler instruction executes at T+2.
- **mret**: mret executes at T, `redirect` at T+1, the resumed instruction at T+2.
- **Instruction loss**: exactly one killed instruction per redirect, plus the killed trapped instruction on entry.
- **Interrupt latency**: minimum 3 cycles from the irq edge to the first handler instruction.

## Test plan
- **Reset**: assert `rst`=0 for 2 cycles mid-REDIRECT. Required: all CSRs read 0, `redirect`=0, `kill`=0.
- **RX trap**:
  - Set mtvec=0x100, mie=0x1_0000, mstatus=0x8.
  - Pulse `uart_rx_irq` while pc=0x40.
  - Required: `kill` in the cycle the take condition holds; `redirect`=1 with `redirect_pc`=0x100 the next cycle.
  - Required: mepc=0x40, mcause=0x8000_0010, mstatus=0x80, RXP=0.
- **mret**: after the RX trap, issue mret. Required: `redirect_pc`=0x40 one cycle later, mstatus=0x88, no `kill` on the mret cycle.
- **Priority**:
  - RX and TX edges in the same cycle, both enabled: RX is taken first.
  - After mret, TX is taken with mcause=0x8000_0011.
- **Masking**: MIE=0 with pending RX. Required: no `take`; mip=0x1_0000 holds; the trap is taken on the first instruction boundary with no `csr_wre` after a `csr_wre` write sets MIE=1.
- **Collision**: `is_mret` in the same cycle as a pending enabled interrupt. Required: mret redirect to mepc first; the interrupt is taken on the first valid instruction after the redirect.
